m_serial_adder_ctrl: RTL and testbench

//  Bit-serial adder sequencer: accepts two WIDTH-bit operands plus carry-in over a

---
 rtl/m_serial_adder_ctrl_pkg.sv | 19 +
 rtl/m_serial_adder_ctrl_fa.sv | 41 ++++
 rtl/m_serial_adder_ctrl.sv | 147 ++++++++++++++
 tb/tb_m_serial_adder_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/m_serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// m_serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial adder sequencer.
//   Contents:
//     state_t  - sequencer state encoding (IDLE=0, RUN=1, DONE=2; 3 is
//                illegal and is steered back to IDLE by the next-state logic)
//     STATE_W  - width of the state encoding, used for the debug port
// ---------------------------------------------------------------------------
package m_serial_adder_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : m_serial_adder_ctrl_pkg

// File: rtl/m_serial_adder_ctrl_fa.sv
// ---------------------------------------------------------------------------
// m_ha / m_FA
//   One-bit full adder assembled from two half adders and an OR gate.
//   The sequencer shares a single m_FA instance across all operand bits.
//   m_ha ports:
//     w_a, w_b  in   addend bits
//     w_s       out  a ^ b
//     w_c       out  a & b
//   m_FA ports:
//     w_a, w_b  in   addend bits
//     w_ci      in   carry in
//     w_co      out  carry out
//     w_s       out  sum bit
// ---------------------------------------------------------------------------
module m_ha (
    input  logic w_a,
    input  logic w_b,
    output logic w_s,
    output logic w_c
);
    assign w_s = w_a ^ w_b;
    assign w_c = w_a & w_b;
endmodule : m_ha

module m_FA (
    input  logic w_a,
    input  logic w_b,
    input  logic w_ci,
    output logic w_co,
    output logic w_s
);
    logic s0;
    logic c0;
    logic c1;

    m_ha u_ha0 (.w_a(w_a), .w_b(w_b),  .w_s(s0),  .w_c(c0));
    m_ha u_ha1 (.w_a(s0),  .w_b(w_ci), .w_s(w_s), .w_c(c1));

    // Both half-adder carries can never be high together, so OR suffices.
    assign w_co = c0 | c1;
endmodule : m_FA

// File: rtl/m_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// m_serial_adder_ctrl
//   Bit-serial adder sequencer. Accepts A, B and carry-in on an input
//   valid/ready handshake, feeds them LSB-first through one shared full-adder
//   cell over WIDTH cycles, and presents sum and carry-out on an output
//   valid/ready handshake.
//
//   Handshake rule (both sides): a transfer happens on a rising edge where
//   valid and ready are both high. Ready/valid driven by this block depend
//   only on registered state; valid/ready driven by the neighbours are
//   ignored outside IDLE (input side) or DONE (output side). No queuing.
//
//   Parameters:
//     WIDTH  operand/sum width (>= 1)
//     CNT_W  bit counter width, 2**CNT_W must be >= WIDTH
//   Ports:
//     w_clk        in   clock, rising edge
//     w_rst_n      in   asynchronous active-low reset
//     w_in_valid   in   operand request valid
//     w_in_ready   out  high in IDLE
//     w_a, w_b     in   operands (sampled only at the accept edge)
//     w_cin        in   carry in (sampled only at the accept edge)
//     w_out_valid  out  high in DONE
//     w_out_ready  in   sink accepts result
//     w_sum        out  low WIDTH bits of A+B+cin
//     w_cout       out  bit WIDTH of A+B+cin
//     w_busy       out  high in RUN or DONE
//     w_dbg_state  out  current state encoding, for observation only
// ---------------------------------------------------------------------------
module m_serial_adder_ctrl
    import m_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic               w_clk,
    input  logic               w_rst_n,
    input  logic               w_in_valid,
    output logic               w_in_ready,
    input  logic [WIDTH-1:0]   w_a,
    input  logic [WIDTH-1:0]   w_b,
    input  logic               w_cin,
    output logic               w_out_valid,
    input  logic               w_out_ready,
    output logic [WIDTH-1:0]   w_sum,
    output logic               w_cout,
    output logic               w_busy,
    output logic [STATE_W-1:0] w_dbg_state
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_shift;
    logic               c_q;
    logic               fa_s;
    logic               fa_co;
    logic               last_bit;

    // Single shared adder cell: always looks at the current LSBs and carry.
    m_FA u_fa (
        .w_a  (a_q[0]),
        .w_b  (b_q[0]),
        .w_ci (c_q),
        .w_co (fa_co),
        .w_s  (fa_s)
    );

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at bit 0.
    // A one-bit sum register has nothing to shift down, hence the split.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_shift = fa_s;
        end else begin : g_sum_wn
            assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
        end
    endgenerate

    // Counter value during the final RUN cycle.
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // ---------------- state register ----------------
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_bit)    state_d = ST_DONE;
            ST_DONE: if (w_out_ready) state_d = ST_IDLE;
            // Encoding 2'd3 is unreachable in normal operation; recover.
            default:                  state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            c_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_in_valid) begin
                        a_q   <= w_a;
                        b_q   <= w_b;
                        c_q   <= w_cin;
                        sum_q <= '0;
                        cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    sum_q <= sum_shift;
                    c_q   <= fa_co;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: begin
                    // DONE (and the illegal code) hold the result registers.
                end
            endcase
        end
    end

    // ---------------- outputs: pure decodes of registered state ----------------
    assign w_in_ready  = (state_q == ST_IDLE);
    assign w_out_valid = (state_q == ST_DONE);
    assign w_busy      = (state_q != ST_IDLE);
    assign w_sum       = sum_q;
    assign w_cout      = c_q;
    assign w_dbg_state = state_q;

endmodule : m_serial_adder_ctrl

// File: tb/tb_m_serial_adder_ctrl.sv
module tb_m_serial_adder_ctrl;

  localparam int W8 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- WIDTH=8 DUT ----------------
  logic          in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [W8-1:0] a, b, sum;
  logic [1:0]    dbg_state;

  m_serial_adder_ctrl #(.WIDTH(W8), .CNT_W(3)) u_dut8 (
    .w_clk(clk), .w_rst_n(rst_n),
    .w_in_valid(in_valid), .w_in_ready(in_ready),
    .w_a(a), .w_b(b), .w_cin(cin),
    .w_out_valid(out_valid), .w_out_ready(out_ready),
    .w_sum(sum), .w_cout(cout), .w_busy(busy), .w_dbg_state(dbg_state)
  );

  // ---------------- WIDTH=1 DUT ----------------
  logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
  logic [0:0] a1, b1, sum1;
  logic [1:0] dbg_state1;

  m_serial_adder_ctrl #(.WIDTH(1), .CNT_W(3)) u_dut1 (
    .w_clk(clk), .w_rst_n(rst_n),
    .w_in_valid(in_valid1), .w_in_ready(in_ready1),
    .w_a(a1), .w_b(b1), .w_cin(cin1),
    .w_out_valid(out_valid1), .w_out_ready(out_ready1),
    .w_sum(sum1), .w_cout(cout1), .w_busy(busy1), .w_dbg_state(dbg_state1)
  );

  // ---------------- scoreboard state ----------------
  logic [W8:0] exp_q[$];    // {cout, sum} expected, WIDTH=8
  int          lat_q[$];    // handshake cycle of each accepted op
  logic [1:0]  exp1_q[$];   // {cout, sum} expected, WIDTH=1
  int          lat1_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        prev_v = 1'b0;
  logic        prev_v1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // All driving and direct checks happen 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    int n = 0;
    in_valid = 1'b1; a = ta; b = tb; cin = tc;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin
      fail_now("accept8");
    end else begin
      exp_q.push_back({1'b0, ta} + {1'b0, tb} + {8'd0, tc});
      lat_q.push_back(cyc);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drive_op1(input logic ta, input logic tb, input logic tc);
    int n = 0;
    in_valid1 = 1'b1; a1 = ta; b1 = tb; cin1 = tc;
    while (!in_ready1 && n < 50) begin tick(); n++; end
    if (!in_ready1) begin
      fail_now("accept1");
    end else begin
      exp1_q.push_back({1'b0, ta} + {1'b0, tb} + {1'b0, tc});
      lat1_q.push_back(cyc);
    end
    tick();
    in_valid1 = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 100) begin tick(); n++; end
    if (n >= 100) fail_now("wait_done8");
  endtask

  task automatic wait_done1();
    int n = 0;
    while ((exp1_q.size() != 0 || !in_ready1) && n < 100) begin tick(); n++; end
    if (n >= 100) fail_now("wait_done1");
  endtask

  // ---------------- monitors (negedge, decoupled from stimulus) ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (lat_q.size() == 0) fail_now("unexpected_valid8");
        else check("latency8", cyc - lat_q.pop_front(), W8 + 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result8");
        else check("result8", {cout, sum}, exp_q.pop_front());
      end
      prev_v = out_valid;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v1 = 1'b0;
    end else begin
      if (out_valid1 && !prev_v1) begin
        if (lat1_q.size() == 0) fail_now("unexpected_valid1");
        else check("latency1", cyc - lat1_q.pop_front(), 2);
      end
      if (out_valid1 && out_ready1) begin
        if (exp1_q.size() == 0) fail_now("unexpected_result1");
        else check("result1", {cout1, sum1}, exp1_q.pop_front());
      end
      prev_v1 = out_valid1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    check("rst_in_ready1", in_ready1, 1);
    rst_n = 1'b1;
    tick();

    // Basic additions, including carry-out cases
    drive_op(8'h5A, 8'h33, 1'b0);   // 0x08D
    check("busy_run", busy, 1);
    check("in_ready_run", in_ready, 0);
    wait_done();
    drive_op(8'hFF, 8'h01, 1'b0);   // 0x100
    wait_done();
    drive_op(8'hFF, 8'hFF, 1'b1);   // 0x1FF
    wait_done();
    drive_op(8'h80, 8'h80, 1'b0);   // 0x100
    wait_done();

    // Backpressure: hold the result in DONE for 5 cycles
    out_ready = 1'b0;
    drive_op(8'h3C, 8'h4F, 1'b1);   // 0x08C
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) fail_now("bp_wait_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", sum, 8'h8C);
      check("bp_cout", cout, 0);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_state", dbg_state, 0);

    // In-valid during RUN is ignored
    drive_op(8'h12, 8'h34, 1'b1);   // 0x047
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    check("ign_in_ready", in_ready, 0);
    tick();
    tick();
    in_valid = 1'b0;
    wait_done();
    repeat (3) tick();
    check("ign_no_extra", out_valid, 0);

    // Reset in the middle of RUN
    drive_op(8'h77, 8'h11, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    drive_op(8'h01, 8'h01, 1'b0);   // 0x002
    wait_done();

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      drive_op1(v[2], v[1], v[0]);
    end
    wait_done1();

    check("drain8", exp_q.size(), 0);
    check("drain1", exp1_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_m_serial_adder_ctrl
